// File: rtl/accelerator_retention_vector.sv
// rtl/accelerator_retention_vector.sv - retention vector psi(t;j) = prod_i (ONE - f(t;i)*w_r(t-1;i,j))
// Unsigned fixed point with FRACTION_SIZE fraction bits; CONTROL_SIZE carries no internal function.
module accelerator_retention_vector #(
   parameter int DATA_SIZE     = 64,
   parameter int CONTROL_SIZE  = 64,
   parameter int FRACTION_SIZE = 32,
   parameter int MAX_R         = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   output logic                 READY,
   input  logic                 F_IN_ENABLE,
   input  logic                 W_IN_ENABLE,
   output logic                 F_OUT_ENABLE,
   output logic                 W_OUT_ENABLE,
   output logic                 PSI_OUT_ENABLE,
   input  logic [DATA_SIZE-1:0] SIZE_R_IN,
   input  logic [DATA_SIZE-1:0] SIZE_N_IN,
   input  logic [DATA_SIZE-1:0] F_IN,
   input  logic [DATA_SIZE-1:0] W_IN,
   output logic [DATA_SIZE-1:0] PSI_OUT
);
   localparam int IW = ((MAX_R > 1) ? $clog2(MAX_R) : 1) + 0 * CONTROL_SIZE;
   localparam logic [DATA_SIZE-1:0] ONE     = DATA_SIZE'(1) << FRACTION_SIZE;
   localparam logic [DATA_SIZE-1:0] MAX_R_W = DATA_SIZE'(MAX_R);

   typedef enum logic [2:0] {STARTER, F_LOAD, W_LOAD, W_MULT, PSI_EMIT} state_t;

   state_t                 state, state_n;
   logic [DATA_SIZE-1:0]   r_last, r_last_n, n_last, n_last_n;
   logic [DATA_SIZE-1:0]   j, j_n, acc, acc_n, p, p_n, psi_n;
   logic [IW-1:0]          i, i_n;
   logic [DATA_SIZE-1:0]   f_mem [MAX_R];
   logic                   f_we;
   logic                   ready_n, f_en_n, w_en_n, psi_en_n;
   logic [DATA_SIZE-1:0]   i_ext, f_sel, term, acc_mult, p_calc;
   logic [2*DATA_SIZE-1:0] fw_prod, acc_prod;
   logic                   size_ok, i_last, j_last;

   assign i_ext    = DATA_SIZE'(i);
   assign f_sel    = f_mem[i];
   assign fw_prod  = {{DATA_SIZE{1'b0}}, f_sel} * {{DATA_SIZE{1'b0}}, W_IN};
   assign p_calc   = DATA_SIZE'(fw_prod >> FRACTION_SIZE);
   // A product above ONE would make the factor negative; clamp it to zero.
   assign term     = (p <= ONE) ? (ONE - p) : '0;
   assign acc_prod = {{DATA_SIZE{1'b0}}, acc} * {{DATA_SIZE{1'b0}}, term};
   assign acc_mult = DATA_SIZE'(acc_prod >> FRACTION_SIZE);
   assign i_last   = (i_ext == r_last);
   assign j_last   = (j == n_last);
   assign size_ok  = (SIZE_R_IN != '0) && (SIZE_R_IN <= MAX_R_W) && (SIZE_N_IN != '0);

   always_comb begin
      state_n  = state;
      r_last_n = r_last;
      n_last_n = n_last;
      i_n      = i;
      j_n      = j;
      acc_n    = acc;
      p_n      = p;
      psi_n    = PSI_OUT;
      f_we     = 1'b0;
      ready_n  = 1'b0;
      f_en_n   = 1'b0;
      w_en_n   = 1'b0;
      psi_en_n = 1'b0;
      case (state)
         STARTER: begin
            if (START) begin
               if (size_ok) begin
                  r_last_n = SIZE_R_IN - DATA_SIZE'(1);
                  n_last_n = SIZE_N_IN - DATA_SIZE'(1);
                  i_n      = '0;
                  j_n      = '0;
                  f_en_n   = 1'b1;
                  state_n  = F_LOAD;
               end else begin
                  ready_n = 1'b1;
               end
            end
         end
         F_LOAD: begin
            if (F_IN_ENABLE) begin
               f_we = 1'b1;
               if (!i_last) begin
                  i_n    = i + IW'(1);
                  f_en_n = 1'b1;
               end else begin
                  i_n     = '0;
                  acc_n   = ONE;
                  w_en_n  = 1'b1;
                  state_n = W_LOAD;
               end
            end
         end
         W_LOAD: begin
            if (W_IN_ENABLE) begin
               p_n     = p_calc;
               state_n = W_MULT;
            end
         end
         W_MULT: begin
            if (!i_last) begin
               acc_n   = acc_mult;
               i_n     = i + IW'(1);
               w_en_n  = 1'b1;
               state_n = W_LOAD;
            end else begin
               // Column finished: publish it and, if more remain, request the next column's first w now.
               psi_n    = acc_mult;
               psi_en_n = 1'b1;
               i_n      = '0;
               state_n  = PSI_EMIT;
               if (!j_last) begin
                  acc_n  = ONE;
                  w_en_n = 1'b1;
               end else begin
                  acc_n  = acc_mult;
               end
            end
         end
         PSI_EMIT: begin
            if (!j_last) begin
               j_n = j + DATA_SIZE'(1);
               // The w request is already outstanding, so an immediate reply is taken here.
               if (W_IN_ENABLE) begin
                  p_n     = p_calc;
                  state_n = W_MULT;
               end else begin
                  state_n = W_LOAD;
               end
            end else begin
               ready_n = 1'b1;
               state_n = STARTER;
            end
         end
         default: state_n = STARTER;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state          <= STARTER;
         r_last         <= '0;
         n_last         <= '0;
         i              <= '0;
         j              <= '0;
         acc            <= '0;
         p              <= '0;
         PSI_OUT        <= '0;
         READY          <= 1'b0;
         F_OUT_ENABLE   <= 1'b0;
         W_OUT_ENABLE   <= 1'b0;
         PSI_OUT_ENABLE <= 1'b0;
         for (int k = 0; k < MAX_R; k++) f_mem[k] <= '0;
      end else begin
         state          <= state_n;
         r_last         <= r_last_n;
         n_last         <= n_last_n;
         i              <= i_n;
         j              <= j_n;
         acc            <= acc_n;
         p              <= p_n;
         PSI_OUT        <= psi_n;
         READY          <= ready_n;
         F_OUT_ENABLE   <= f_en_n;
         W_OUT_ENABLE   <= w_en_n;
         PSI_OUT_ENABLE <= psi_en_n;
         if (f_we) f_mem[i] <= F_IN;
      end
   end
endmodule

// File: tb/tb_accelerator_retention_vector.sv
// tb/tb_accelerator_retention_vector.sv - randomized bench with arithmetic reference model
module tb_accelerator_retention_vector;
   localparam int DW = 16;
   localparam int FW = 8;
   localparam int MR = 4;

   logic          CLK, RST, START, READY;
   logic          F_IN_ENABLE, W_IN_ENABLE, F_OUT_ENABLE, W_OUT_ENABLE, PSI_OUT_ENABLE;
   logic [DW-1:0] SIZE_R_IN, SIZE_N_IN, F_IN, W_IN, PSI_OUT;

   accelerator_retention_vector #(
      .DATA_SIZE(DW), .CONTROL_SIZE(64), .FRACTION_SIZE(FW), .MAX_R(MR)
   ) dut (
      .CLK(CLK), .RST(RST), .START(START), .READY(READY),
      .F_IN_ENABLE(F_IN_ENABLE), .W_IN_ENABLE(W_IN_ENABLE),
      .F_OUT_ENABLE(F_OUT_ENABLE), .W_OUT_ENABLE(W_OUT_ENABLE), .PSI_OUT_ENABLE(PSI_OUT_ENABLE),
      .SIZE_R_IN(SIZE_R_IN), .SIZE_N_IN(SIZE_N_IN), .F_IN(F_IN), .W_IN(W_IN), .PSI_OUT(PSI_OUT)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int n_checks = 0;
   int n_pass   = 0;
   int f_vals [MR];
   int w_mat  [MR][8];
   int exp_psi[8];
   int psi_q[$];
   int ready_cnt, w_req_cnt, f_req_cnt, lat_bad, excl_bad, rdy_gap, timed_out;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic void model(input int r, input int n);
      for (int j = 0; j < n; j++) begin
         longint acc = 256;
         for (int i = 0; i < r; i++) begin
            longint p    = ((longint'(f_vals[i]) * longint'(w_mat[i][j])) >> 8) & 64'hFFFF;
            longint term = (p <= 256) ? 256 - p : 0;
            acc = ((acc * term) >> 8) & 64'hFFFF;
         end
         exp_psi[j] = int'(acc);
      end
   endfunction

   task automatic run_job(input int r, input int n, input bit hold_w, input bit poke, input bit abort);
      int  f_pend = 0, w_pend = 0, f_idx = 0, w_idx = 0, w_drv = -1, last_psi = -1, act = 0;
      bit  done = 0;
      psi_q.delete();
      ready_cnt = 0; w_req_cnt = 0; f_req_cnt = 0; lat_bad = 0; excl_bad = 0; rdy_gap = -1; timed_out = 0;
      @(negedge CLK);
      SIZE_R_IN = DW'(r); SIZE_N_IN = DW'(n); START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
         if (F_OUT_ENABLE) begin f_pend++; f_req_cnt++; end
         if (W_OUT_ENABLE) begin w_pend++; w_req_cnt++; end
         if ((W_OUT_ENABLE || PSI_OUT_ENABLE) && w_drv >= 0) begin
            if (cyc - w_drv != 2) lat_bad++;
            w_drv = -1;
         end
         if (F_OUT_ENABLE && (W_OUT_ENABLE || PSI_OUT_ENABLE)) excl_bad++;
         if (PSI_OUT_ENABLE) begin
            if (W_OUT_ENABLE != (psi_q.size() < n - 1)) excl_bad++;
            psi_q.push_back(int'(PSI_OUT));
            last_psi = cyc;
         end
         if (READY) begin ready_cnt++; rdy_gap = cyc - last_psi; done = 1; end
         if (abort && w_req_cnt == 2) begin
            RST = 1'b0;
            #1;
            check("rst_ready",  READY, 0);
            check("rst_fen",    F_OUT_ENABLE, 0);
            check("rst_wen",    W_OUT_ENABLE, 0);
            check("rst_psien",  PSI_OUT_ENABLE, 0);
            check("rst_psiout", PSI_OUT, 0);
            START = 1'b0; F_IN_ENABLE = 1'b0; W_IN_ENABLE = 1'b0;
            @(negedge CLK);
            RST = 1'b1;
            for (int k = 0; k < 10; k++) begin
               @(negedge CLK);
               act += int'(READY) + int'(F_OUT_ENABLE) + int'(W_OUT_ENABLE) + int'(PSI_OUT_ENABLE);
            end
            check("abort_quiet", act, 0);
            return;
         end
         if (done) begin
            START = 1'b0; F_IN_ENABLE = 1'b0; W_IN_ENABLE = 1'b0;
         end else begin
            F_IN_ENABLE = 1'b0;
            F_IN = DW'($urandom);
            if (f_pend > 0) begin
               if ($urandom_range(0, 2) != 0) begin
                  F_IN_ENABLE = 1'b1; F_IN = DW'(f_vals[f_idx]); f_idx++; f_pend--;
               end
            end else if ($urandom_range(0, 3) == 0) F_IN_ENABLE = 1'b1;
            if (hold_w) begin
               W_IN_ENABLE = 1'b1;
               if (w_pend > 0) begin
                  W_IN = DW'(w_mat[w_idx % r][w_idx / r]); w_idx++; w_pend--;
               end
            end else begin
               W_IN_ENABLE = 1'b0;
               W_IN = DW'($urandom);
               if (w_pend > 0) begin
                  if ($urandom_range(0, 2) != 0) begin
                     W_IN_ENABLE = 1'b1; W_IN = DW'(w_mat[w_idx % r][w_idx / r]);
                     w_idx++; w_pend--; w_drv = cyc;
                  end
               end else if ($urandom_range(0, 3) == 0) W_IN_ENABLE = 1'b1;
            end
            SIZE_R_IN = DW'($urandom);
            SIZE_N_IN = DW'($urandom);
            START = poke ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         @(negedge CLK);
      end
      if (!done) timed_out = 1;
      START = 1'b0; F_IN_ENABLE = 1'b0; W_IN_ENABLE = 1'b0;
   endtask

   task automatic verify_job(input int r, input int n);
      model(r, n);
      check("timeout",   timed_out, 0);
      check("psi_count", psi_q.size(), n);
      for (int j = 0; j < n; j++)
         check($sformatf("psi_%0d", j), (j < psi_q.size()) ? psi_q[j] : -1, exp_psi[j]);
      check("ready_count", ready_cnt, 1);
      check("ready_gap",   rdy_gap, 1);
      check("f_requests",  f_req_cnt, r);
      check("w_requests",  w_req_cnt, r * n);
      check("w_latency",   lat_bad, 0);
      check("enable_rule", excl_bad, 0);
   endtask

   task automatic bad_start(input int r, input int n);
      int act = 0;
      @(negedge CLK);
      SIZE_R_IN = DW'(r); SIZE_N_IN = DW'(n); START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      check("bad_ready", READY, 1);
      act = int'(F_OUT_ENABLE) + int'(W_OUT_ENABLE) + int'(PSI_OUT_ENABLE);
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         act += int'(READY) + int'(F_OUT_ENABLE) + int'(W_OUT_ENABLE) + int'(PSI_OUT_ENABLE);
      end
      check("bad_quiet", act, 0);
   endtask

   task automatic set_req022();
      f_vals[0] = 'h80;  f_vals[1] = 'h100;
      w_mat[0][0] = 'h100; w_mat[1][0] = 'h80;
      w_mat[0][1] = 'h0;   w_mat[1][1] = 'h0;
   endtask

   task automatic fill_random(input int r, input int n);
      for (int i = 0; i < r; i++) begin
         f_vals[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(257, 1023)) : int'($urandom_range(0, 256));
         for (int j = 0; j < n; j++)
            w_mat[i][j] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(257, 511)) : int'($urandom_range(0, 256));
      end
   endtask

   initial begin
      RST = 1'b0; START = 1'b0; F_IN_ENABLE = 1'b0; W_IN_ENABLE = 1'b0;
      SIZE_R_IN = '0; SIZE_N_IN = '0; F_IN = '0; W_IN = '0;
      repeat (3) @(negedge CLK);
      check("init_ready",  READY, 0);
      check("init_fen",    F_OUT_ENABLE, 0);
      check("init_wen",    W_OUT_ENABLE, 0);
      check("init_psien",  PSI_OUT_ENABLE, 0);
      check("init_psiout", PSI_OUT, 0);
      RST = 1'b1;

      f_vals[0] = 'h100; w_mat[0][0] = 'h80;
      run_job(1, 1, 0, 0, 0);
      verify_job(1, 1);
      check("r1n1_psi", (psi_q.size() > 0) ? psi_q[0] : -1, 'h80);

      set_req022();
      run_job(2, 2, 0, 0, 0);
      verify_job(2, 2);
      check("r2n2_psi0", (psi_q.size() > 0) ? psi_q[0] : -1, 'h40);
      check("r2n2_psi1", (psi_q.size() > 1) ? psi_q[1] : -1, 'h100);

      run_job(2, 2, 0, 0, 1);
      set_req022();
      run_job(2, 2, 0, 0, 0);
      verify_job(2, 2);
      check("after_abort_psi0", (psi_q.size() > 0) ? psi_q[0] : -1, 'h40);
      check("after_abort_psi1", (psi_q.size() > 1) ? psi_q[1] : -1, 'h100);

      f_vals[0] = 'h200; w_mat[0][0] = 'h100;
      run_job(1, 1, 0, 0, 0);
      verify_job(1, 1);
      check("saturate_psi", (psi_q.size() > 0) ? psi_q[0] : -1, 0);

      bad_start(5, 1);
      bad_start(2, 0);
      bad_start(0, 3);

      fill_random(3, 3);
      run_job(3, 3, 1, 1, 0);
      verify_job(3, 3);

      for (int t = 0; t < 12; t++) begin
         int r = int'($urandom_range(1, MR));
         int n = int'($urandom_range(1, 6));
         fill_random(r, n);
         run_job(r, n, (t % 4) == 3, (t % 2) == 1, 0);
         verify_job(r, n);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
